// File: rtl/midi_pkg.sv
// midi_pkg: shared constants and type definitions for the midi_gate block.
package midi_pkg;

    // Status nibble values
    localparam logic [3:0] NOTE_OFF = 4'h8;
    localparam logic [3:0] NOTE_ON  = 4'h9;
    localparam logic [3:0] PROG     = 4'hC;
    localparam logic [3:0] CHPRESS  = 4'hD;

    // System common starts here; realtime bytes sit at and above REALTIME
    localparam logic [7:0] SYS_COMMON = 8'hF0;
    localparam logic [7:0] REALTIME   = 8'hF8;

    localparam int STACK_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        D1   = 2'd1,
        D2   = 2'd2
    } parse_state_t;

    // Running status as seen by the parser; IGN1/IGN2 skip 1- or 2-byte messages
    typedef enum logic [2:0] {
        RS_NONE = 3'd0,
        RS_OFF  = 3'd1,
        RS_ON   = 3'd2,
        RS_IGN1 = 3'd3,
        RS_IGN2 = 3'd4
    } run_status_t;

endpackage

// File: rtl/note_stack.sv
// note_stack: 4-deep held-note stack, entry 0 is the most recent note.
// Outputs top_o/empty_o reflect the stack after the current strobe is applied,
// so the parent can register them on the same edge as the stack update.
module note_stack
    import midi_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       push_i,
    input  logic       remove_i,
    input  logic [6:0] note_i,
    output logic [6:0] top_o,
    output logic       empty_o,
    output logic       was_top_o,
    output logic       hit_o
);

    logic [STACK_DEPTH-1:0][6:0] ent_q, ent_d;
    logic [2:0]                  cnt_q, cnt_d;
    logic                        hit;
    logic [1:0]                  pos;
    logic [1:0]                  shift_to;

    // Locate note_i among the valid entries (lowest index wins)
    always_comb begin
        hit = 1'b0;
        pos = 2'd0;
        for (int i = STACK_DEPTH - 1; i >= 0; i--) begin
            if (i < int'(cnt_q) && ent_q[i] == note_i) begin
                hit = 1'b1;
                pos = 2'(i);
            end
        end
    end

    // Next stack contents: push moves/inserts at the top, remove closes the gap
    always_comb begin
        ent_d    = ent_q;
        cnt_d    = cnt_q;
        shift_to = hit ? pos : 2'(STACK_DEPTH - 1);
        if (push_i) begin
            for (int j = STACK_DEPTH - 1; j > 0; j--) begin
                if (j <= int'(shift_to)) ent_d[j] = ent_q[j-1];
            end
            ent_d[0] = note_i;
            if (!hit && cnt_q != 3'(STACK_DEPTH)) cnt_d = cnt_q + 3'd1;
        end else if (remove_i && hit) begin
            for (int j = 0; j < STACK_DEPTH - 1; j++) begin
                if (j >= int'(pos)) ent_d[j] = ent_q[j+1];
            end
            cnt_d = cnt_q - 3'd1;
        end
    end

    assign top_o     = ent_d[0];
    assign empty_o   = (cnt_d == 3'd0);
    assign was_top_o = remove_i && hit && (pos == 2'd0);
    assign hit_o     = hit;

    // Stack storage
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ent_q <= '0;
            cnt_q <= '0;
        end else begin
            ent_q <= ent_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/midi_gate.sv
// midi_gate: MIDI byte stream to monophonic GATE/NOTE/VELOCITY.
// Define MIDI_GATE_STACK_EN to enable the 4-entry last-note-priority stack;
// without it a note-off only releases the currently sounding note.
//
// state | meaning
// IDLE  | no usable running status, data bytes dropped
// D1    | awaiting note byte (or skipping data of an ignored message)
// D2    | awaiting velocity byte
module midi_gate
    import midi_pkg::*;
#(
    parameter logic [3:0] CHANNEL = 4'h0
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       LOCKED,
    input  logic [7:0] MIDI_DATA,
    input  logic       MIDI_VALID,
    output logic       GATE,
    output logic [6:0] NOTE,
    output logic [6:0] VELOCITY
);

    parse_state_t state_q;
    run_status_t  rs_q;
    logic [6:0]   nbyte_q;

    logic gate_q, gate_d;
    logic retrig_q, retrig_d;
    logic [6:0] note_q, note_d;
    logic [6:0] vel_q, vel_d;

    logic take, exec, note_on_ev, note_off_ev;

    assign take        = MIDI_VALID && LOCKED;
    assign exec        = take && !MIDI_DATA[7] && (state_q == D2)
                         && (rs_q == RS_ON || rs_q == RS_OFF);
    assign note_on_ev  = exec && (rs_q == RS_ON) && (MIDI_DATA[6:0] != 7'd0);
    assign note_off_ev = exec && !note_on_ev;

`ifdef MIDI_GATE_STACK_EN
    logic [6:0] stk_top;
    logic       stk_empty, stk_was_top, stk_hit;

    note_stack u_stack (
        .clk_i     (CLK),
        .rst_i     (RST),
        .push_i    (note_on_ev),
        .remove_i  (note_off_ev),
        .note_i    (nbyte_q),
        .top_o     (stk_top),
        .empty_o   (stk_empty),
        .was_top_o (stk_was_top),
        .hit_o     (stk_hit)
    );
`endif

    // Byte parser: running status, channel filter and data byte counting
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            rs_q    <= RS_NONE;
            nbyte_q <= '0;
        end else if (take && MIDI_DATA < REALTIME) begin
            if (MIDI_DATA >= SYS_COMMON) begin
                state_q <= IDLE;
                rs_q    <= RS_NONE;
            end else if (MIDI_DATA[7]) begin
                state_q <= D1;
                if (MIDI_DATA[3:0] == CHANNEL && MIDI_DATA[7:4] == NOTE_ON)
                    rs_q <= RS_ON;
                else if (MIDI_DATA[3:0] == CHANNEL && MIDI_DATA[7:4] == NOTE_OFF)
                    rs_q <= RS_OFF;
                else if (MIDI_DATA[7:4] == PROG || MIDI_DATA[7:4] == CHPRESS)
                    rs_q <= RS_IGN1;
                else
                    rs_q <= RS_IGN2;
            end else begin
                case (state_q)
                    D1: begin
                        if (rs_q != RS_IGN1) begin
                            nbyte_q <= MIDI_DATA[6:0];
                            state_q <= D2;
                        end
                    end
                    D2:      state_q <= D1;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    // Voice outputs: retrigger pulse finishes first, a completing message overrides it
    always_comb begin
        gate_d   = gate_q;
        retrig_d = retrig_q;
        note_d   = note_q;
        vel_d    = vel_q;
        if (LOCKED) begin
            if (retrig_q) begin
                gate_d   = 1'b1;
                retrig_d = 1'b0;
            end
            if (note_on_ev) begin
                note_d = nbyte_q;
                vel_d  = MIDI_DATA[6:0];
                if (gate_q) begin
                    gate_d   = 1'b0;
                    retrig_d = 1'b1;
                end else begin
                    gate_d   = 1'b1;
                    retrig_d = 1'b0;
                end
            end else if (note_off_ev) begin
`ifdef MIDI_GATE_STACK_EN
                if (stk_hit) begin
                    if (stk_empty) begin
                        gate_d   = 1'b0;
                        retrig_d = 1'b0;
                    end else if (stk_was_top) begin
                        note_d = stk_top;
                    end
                end
`else
                if (nbyte_q == note_q) begin
                    gate_d   = 1'b0;
                    retrig_d = 1'b0;
                end
`endif
            end
        end
    end

    // Output registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            gate_q   <= 1'b0;
            retrig_q <= 1'b0;
            note_q   <= '0;
            vel_q    <= '0;
        end else begin
            gate_q   <= gate_d;
            retrig_q <= retrig_d;
            note_q   <= note_d;
            vel_q    <= vel_d;
        end
    end

    assign GATE     = gate_q;
    assign NOTE     = note_q;
    assign VELOCITY = vel_q;

endmodule
